// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and helpers for the UART engine arbiter.
//   arb_state_t : arbiter FSM states (idle, strobe issue, wait, ack)
//   arb_op_t    : latched operation of the current grant (transmit/receive)
//   wrap_add    : modular index addition used by the picker and the
//                 round-robin pointer
// ---------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;

    typedef enum logic {OP_TX, OP_RX} arb_op_t;

    localparam int ARB_MIN_PORTS = 2;
    localparam int ARB_MAX_PORTS = 8;

    function automatic int unsigned wrap_add(int unsigned base, int unsigned step,
                                             int unsigned n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/uart_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_arbiter_if
// Requester-side bus of the UART arbiter.
//   tx_req  [N]   : port i wants to transmit (held until its ack)
//   rx_req  [N]   : port i wants to receive  (held until its ack)
//   tx_byte [8N]  : port i's transmit byte in [8i+7:8i]
//   ack     [N]   : one-cycle completion pulse to the owning port
//   rx_byte [8]   : received byte, valid in the ack cycle of a receive
// Modports: master = requesters, slave = arbiter.
// ---------------------------------------------------------------------------
interface uart_arbiter_if #(
    parameter int N_PORTS = 2
);
    logic [N_PORTS-1:0]   tx_req;
    logic [N_PORTS-1:0]   rx_req;
    logic [8*N_PORTS-1:0] tx_byte;
    logic [N_PORTS-1:0]   ack;
    logic [7:0]           rx_byte;

    modport master (
        output tx_req,
        output rx_req,
        output tx_byte,
        input  ack,
        input  rx_byte
    );

    modport slave (
        input  tx_req,
        input  rx_req,
        input  tx_byte,
        output ack,
        output rx_byte
    );
endinterface

// File: rtl/uart_arb_pick.sv
// ---------------------------------------------------------------------------
// uart_arb_pick
// Combinational picker: scans the pending vector starting at index 'start'
// and wrapping around, returning the first pending port.
//   pending [N] : per-port request vector
//   start   [W] : index scanned first
//   found       : at least one port is pending
//   winner  [W] : index of the selected port (0 when none)
// ---------------------------------------------------------------------------
module uart_arb_pick
    import uart_arb_pkg::*;
#(
    parameter  int N_PORTS = 2,
    localparam int IW      = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] pending,
    input  logic [IW-1:0]      start,
    output logic               found,
    output logic [IW-1:0]      winner
);

    logic [IW-1:0] cand;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = IW'(wrap_add(32'(start), k, N_PORTS));
            if (!found && pending[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/uart_arbiter.sv
// ---------------------------------------------------------------------------
// uart_arbiter
// Shares one byte-level UART engine between N_PORTS requesters. One transfer
// is granted at a time: a single t_valid/r_valid strobe is issued, the
// matching engine completion pulse is awaited, then a one-cycle ack (and the
// received byte for receives) goes back to the owner.
//
// Ports
//   clk, rstn          : clock, asynchronous active-low reset
//   req   (slave)      : requester bus (tx_req, rx_req, tx_byte, ack, rx_byte)
//   busy               : transfer in flight
//   grant              : current or last owner
//   t_valid, r_valid   : strobes to the engine
//   t_data             : byte to the engine
//   tx_done, rx_done   : engine completion pulses
//   r_data             : engine received byte, valid with rx_done
//
// Build option
//   UART_ARB_RR_EN     : defined -> round-robin arbitration (pointer moves to
//                        owner+1 when a transfer completes); undefined ->
//                        fixed priority, lowest index wins, no pointer.
// ---------------------------------------------------------------------------
module uart_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_PORTS = 2,
    localparam int GW      = $clog2(N_PORTS)
) (
    input  logic          clk,
    input  logic          rstn,
    uart_arbiter_if.slave req,
    output logic          busy,
    output logic [GW-1:0] grant,
    output logic          t_valid,
    output logic          r_valid,
    output logic [7:0]    t_data,
    input  logic          tx_done,
    input  logic          rx_done,
    input  logic [7:0]    r_data
);

    arb_state_t         state_q, state_d;
    arb_op_t            op_q, op_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [7:0]         t_data_q, t_data_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic [N_PORTS-1:0] ack_q, ack_d;
    logic               t_valid_q, t_valid_d;
    logic               r_valid_q, r_valid_d;
    logic               busy_q, busy_d;

    logic [N_PORTS-1:0] pending;
    logic [GW-1:0]      pick_start;
    logic               pick_found;
    logic [GW-1:0]      pick_winner;
    logic [7:0]         sel_byte;

    assign pending = req.tx_req | req.rx_req;

`ifdef UART_ARB_RR_EN
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;

    // The scan after a completed transfer starts just past its owner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == ARB_DONE) begin
            rr_ptr_d = GW'(wrap_add(32'(grant_q), 1, N_PORTS));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign pick_start = rr_ptr_q;
`else
    assign pick_start = '0;
`endif

    uart_arb_pick #(
        .N_PORTS(N_PORTS)
    ) u_pick (
        .pending(pending),
        .start  (pick_start),
        .found  (pick_found),
        .winner (pick_winner)
    );

    // Byte of the winning port, muxed out of the packed tx_byte bus.
    always_comb begin
        sel_byte = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (pick_winner == GW'(p)) begin
                sel_byte = req.tx_byte[8*p +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the per-grant latches. Arbitration only happens in
    // IDLE; TX wins over RX within a port, leaving RX pending for later.
    // Only the completion pulse matching the latched op is honoured.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        grant_d   = grant_q;
        t_data_d  = t_data_q;
        rx_byte_d = rx_byte_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_winner;
                    op_d     = req.tx_req[pick_winner] ? OP_TX : OP_RX;
                    t_data_d = sel_byte;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (op_q == OP_TX) begin
                    if (tx_done) begin
                        state_d = ARB_DONE;
                    end
                end else if (rx_done) begin
                    rx_byte_d = r_data;
                    state_d   = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in
    // the same cycle the FSM enters the corresponding state.
    always_comb begin
        ack_d     = '0;
        t_valid_d = 1'b0;
        r_valid_d = 1'b0;
        busy_d    = (state_d != ARB_IDLE);
        if (state_d == ARB_ISSUE) begin
            t_valid_d = (op_d == OP_TX);
            r_valid_d = (op_d == OP_RX);
        end
        if (state_d == ARB_DONE) begin
            ack_d[grant_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q      <= OP_TX;
            grant_q   <= '0;
            t_data_q  <= 8'h00;
            rx_byte_q <= 8'h00;
            ack_q     <= '0;
            t_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            op_q      <= op_d;
            grant_q   <= grant_d;
            t_data_q  <= t_data_d;
            rx_byte_q <= rx_byte_d;
            ack_q     <= ack_d;
            t_valid_q <= t_valid_d;
            r_valid_q <= r_valid_d;
            busy_q    <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign grant       = grant_q;
    assign t_valid     = t_valid_q;
    assign r_valid     = r_valid_q;
    assign t_data      = t_data_q;
    assign req.ack     = ack_q;
    assign req.rx_byte = rx_byte_q;

endmodule

// File: tb/tb_uart_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_arbiter
// Scoreboard bench for uart_arbiter. Each round loads per-port op scripts;
// a transaction-level model orders them by the arbitration rule and pushes
// expected grants into a queue. A requester driver, an engine responder and
// an independent monitor run concurrently; the monitor pops and compares on
// every strobe and every ack.
// ---------------------------------------------------------------------------
module tb_uart_arbiter;

    localparam int NP = 4;
    localparam int GW = $clog2(NP);

    typedef struct {
        int       port;
        bit       is_rx;
        bit [7:0] data;
        bit [7:0] rx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          busy;
    logic [GW-1:0] grant;
    logic          t_valid;
    logic          r_valid;
    logic [7:0]    t_data;
    logic          tx_done;
    logic          rx_done;
    logic [7:0]    r_data;

    uart_arbiter_if #(.N_PORTS(NP)) bus ();

    uart_arbiter #(.N_PORTS(NP)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .req    (bus),
        .busy   (busy),
        .grant  (grant),
        .t_valid(t_valid),
        .r_valid(r_valid),
        .t_data (t_data),
        .tx_done(tx_done),
        .rx_done(rx_done),
        .r_data (r_data)
    );

    always #5 clk = ~clk;

    int       vectors     = 0;
    int       miscompares = 0;
    exp_t     exp_q[$];
    bit [7:0] eng_rx_q[$];
    bit [8:0] ops_q[NP][$];
    int       model_ptr   = 0;
    bit [7:0] model_rx    = 8'h00;

    bit       eng_stall      = 1'b0;
    bit       eng_abort      = 1'b0;
    bit       eng_spur_force = 1'b0;
    int       eng_lat_fixed  = 0;
    bit       eng_real       = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name, input string what);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: %s at %0t", name, what, $time);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ack"},     32'(bus.ack),     32'd0);
        checkOutput({tag, "_t_valid"}, 32'(t_valid),     32'd0);
        checkOutput({tag, "_r_valid"}, 32'(r_valid),     32'd0);
        checkOutput({tag, "_busy"},    32'(busy),        32'd0);
        checkOutput({tag, "_grant"},   32'(grant),       32'd0);
        checkOutput({tag, "_t_data"},  32'(t_data),      32'd0);
        checkOutput({tag, "_rx_byte"}, 32'(bus.rx_byte), 32'd0);
    endtask

    // Transaction-level reference: every port with script left is pending at
    // each arbitration; the winner is the first pending port scanning from
    // the pointer (always 0 for fixed priority), its script order already
    // puts TX ahead of RX.
    task automatic modelRound();
        int       idx[NP];
        int       w;
        int       c;
        bit [8:0] h;
        exp_t     e;
        for (int p = 0; p < NP; p++) idx[p] = 0;
        forever begin
            w = -1;
            for (int k = 0; k < NP; k++) begin
                c = (model_ptr + k) % NP;
                if (w < 0 && idx[c] < ops_q[c].size()) w = c;
            end
            if (w < 0) break;
            h = ops_q[w][idx[w]];
            idx[w]++;
            if (h[8]) begin
                model_rx = h[7:0];
                eng_rx_q.push_back(h[7:0]);
            end
            e.port  = w;
            e.is_rx = h[8];
            e.data  = h[7:0];
            e.rx    = model_rx;
            exp_q.push_back(e);
`ifdef UART_ARB_RR_EN
            model_ptr = (w + 1) % NP;
`endif
        end
    endtask

    // Requester driver: each port presents the head of its script, holding
    // RX alongside TX when the next op is a receive, and advances on ack.
    task automatic driveRound();
        int budget;
        bit any;
        budget = 0;
        forever begin
            @(posedge clk);
            #1;
            any = 1'b0;
            for (int p = 0; p < NP; p++) begin
                bus.tx_req[p] = 1'b0;
                bus.rx_req[p] = 1'b0;
                if (ops_q[p].size() > 0) begin
                    any = 1'b1;
                    if (!ops_q[p][0][8]) begin
                        bus.tx_req[p]         = 1'b1;
                        bus.tx_byte[8*p +: 8] = ops_q[p][0][7:0];
                        if (ops_q[p].size() > 1 && ops_q[p][1][8]) bus.rx_req[p] = 1'b1;
                    end else begin
                        bus.rx_req[p] = 1'b1;
                    end
                end
            end
            if (!any) break;
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (rstn && bus.ack[p] && ops_q[p].size() > 0) void'(ops_q[p].pop_front());
            end
            budget++;
            if (budget > 4000) begin
                failNow("round_timeout", "acks still outstanding after 4000 cycles");
                for (int p = 0; p < NP; p++) ops_q[p].delete();
                exp_q.delete();
                eng_rx_q.delete();
                bus.tx_req = '0;
                bus.rx_req = '0;
                break;
            end
        end
    endtask

    task automatic idleCheck();
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        eng_rx_q.delete();
    endtask

    task automatic applyStimulus();
        modelRound();
        driveRound();
        idleCheck();
    endtask

    task automatic injectReset();
        int n;
        n = 0;
        @(negedge clk);
        while (!t_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) failNow("reset_strobe", "no t_valid within 20 cycles, expected one");
        repeat (3) @(negedge clk);
        #2;
        eng_abort = 1'b1;
        rstn      = 1'b0;
        #1;
        checkResetValues("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        eng_abort = 1'b0;
        eng_stall = 1'b0;
        rstn      = 1'b1;
    endtask

    // Engine responder: answers each strobe after a latency with the matching
    // done pulse, optionally preceded by a pulse of the opposite kind.
    initial begin : engine
        bit       is_rx;
        bit       spur;
        bit       aborted;
        int       lat;
        int       spur_at;
        int       cnt;
        bit [7:0] last_rx;
        last_rx = 8'h00;
        forever begin
            @(negedge clk);
            if (rstn && (t_valid || r_valid)) begin
                is_rx   = r_valid;
                lat     = (eng_lat_fixed > 0) ? eng_lat_fixed : int'($urandom_range(1, 12));
                spur    = (lat > 1) && (eng_spur_force || ($urandom_range(0, 3) == 0));
                spur_at = (lat > 1) ? int'($urandom_range(1, lat - 1)) : 0;
                cnt     = 0;
                aborted = 1'b0;
                forever begin
                    @(posedge clk);
                    #1;
                    tx_done  = 1'b0;
                    rx_done  = 1'b0;
                    eng_real = 1'b0;
                    if (eng_abort) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (!eng_stall) cnt++;
                    if (!eng_stall && spur && cnt == spur_at) begin
                        if (is_rx) begin
                            tx_done = 1'b1;
                        end else begin
                            rx_done = 1'b1;
                            r_data  = last_rx ^ 8'h5A;
                        end
                    end
                    if (!eng_stall && cnt == lat) begin
                        eng_real = 1'b1;
                        if (is_rx) begin
                            rx_done = 1'b1;
                            if (eng_rx_q.size() > 0) begin
                                r_data = eng_rx_q.pop_front();
                            end else begin
                                r_data = 8'hEE;
                                failNow("engine_rx", "receive strobe with no receive expected");
                            end
                            last_rx = r_data;
                        end else begin
                            tx_done = 1'b1;
                        end
                        break;
                    end
                end
                if (!aborted) begin
                    @(posedge clk);
                    #1;
                    tx_done  = 1'b0;
                    rx_done  = 1'b0;
                    eng_real = 1'b0;
                end
            end
        end
    end

    // Monitor: checks strobes against the scoreboard head and pops on ack,
    // which must follow a genuine completion pulse by exactly one cycle.
    initial begin : monitor
        bit   prev_strobe;
        bit   due;
        bit   exp_ack;
        exp_t e;
        prev_strobe = 1'b0;
        due         = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_strobe = 1'b0;
                due         = 1'b0;
                continue;
            end
            exp_ack = due;
            due     = eng_real;
            if (t_valid || r_valid) begin
                if (t_valid && r_valid) failNow("dual_strobe", "both strobes high, expected one");
                if (prev_strobe) failNow("strobe_width", "strobe high two cycles, expected one");
                if (exp_q.size() == 0) begin
                    failNow("unexpected_strobe", "strobe seen, none expected");
                end else begin
                    e = exp_q[0];
                    checkOutput("strobe_grant", 32'(grant), 32'(e.port));
                    checkOutput("strobe_op", 32'(r_valid), 32'(e.is_rx));
                    if (!e.is_rx) checkOutput("t_data", 32'(t_data), 32'(e.data));
                    checkOutput("busy_issue", 32'(busy), 32'd1);
                end
            end
            prev_strobe = t_valid || r_valid;
            if (bus.ack != '0 && !exp_ack) begin
                failNow("ack_timing", $sformatf("ack=%0h without a completion, expected 0", bus.ack));
            end else if (exp_ack) begin
                if (exp_q.size() == 0) begin
                    failNow("ack_extra", "completion with empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ack", 32'(bus.ack), 32'(1) << e.port);
                    checkOutput("ack_grant", 32'(grant), 32'(e.port));
                    checkOutput("rx_byte", 32'(bus.rx_byte), 32'(e.rx));
                    checkOutput("busy_done", 32'(busy), 32'd1);
                end
            end
        end
    end

    initial begin : main
        int n_ops;
        rstn        = 1'b0;
        bus.tx_req  = '0;
        bus.rx_req  = '0;
        bus.tx_byte = '0;
        tx_done     = 1'b0;
        rx_done     = 1'b0;
        r_data      = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] single transmit, engine latency 10");
        eng_lat_fixed = 10;
        ops_q[0].push_back({1'b0, 8'hA5});
        applyStimulus();
        eng_lat_fixed = 0;

        $display("[TB] single receive on port 1");
        ops_q[1].push_back({1'b1, 8'h3C});
        applyStimulus();

        $display("[TB] ports 0 and 1 contend with four transmits each");
        for (int i = 0; i < 4; i++) begin
            ops_q[0].push_back({1'b0, 8'(8'h10 + i)});
            ops_q[1].push_back({1'b0, 8'(8'h20 + i)});
        end
        applyStimulus();

        $display("[TB] port 0 transmit and receive together");
        ops_q[0].push_back({1'b0, 8'h77});
        ops_q[0].push_back({1'b1, 8'h96});
        applyStimulus();

        $display("[TB] spurious rx_done during transmit wait");
        eng_spur_force = 1'b1;
        eng_lat_fixed  = 6;
        ops_q[2].push_back({1'b0, 8'hC3});
        applyStimulus();
        eng_spur_force = 1'b0;
        eng_lat_fixed  = 0;

        $display("[TB] reset asserted during wait");
        model_ptr = 0;
        model_rx  = 8'h00;
        eng_stall = 1'b1;
        ops_q[1].push_back({1'b0, 8'h5A});
        modelRound();
        fork
            driveRound();
            injectReset();
        join
        idleCheck();

        $display("[TB] randomized rounds");
        for (int r = 0; r < 30; r++) begin
            for (int p = 0; p < NP; p++) begin
                n_ops = int'($urandom_range(0, 3));
                for (int k = 0; k < n_ops; k++) begin
                    ops_q[p].push_back({1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
                end
            end
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
